// File: rtl/result_port_arbiter.sv
// result_port_arbiter
//   Two-requester arbiter in front of a single-port memory with a one-cycle
//   registered read latency. Each grant covers one burst. A grant ends on a
//   beat marked last, or after MAX_HOLD accepted beats, or when the grantee
//   drops valid. Every grant end goes back through IDLE for one arbitration
//   cycle. Ties are settled round-robin by default. With the macro
//   RESULT_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie.
//   Read data is steered back to the requester that issued the read through a
//   one-bit tag. The tag is registered alongside the memory's read latency.
//
// Parameters
//   DATA_WIDTH  memory word width
//   ADDR_WIDTH  memory address width
//   MAX_HOLD    maximum beats per grant (1..255)
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   reqI_valid/we/addr/wdata/last  beat offered by requester I (I = 0, 1)
//   reqI_ready               beat accepted this cycle
//   reqI_rvalid / reqI_rdata read data return (rdata mirrors mem_rdata)
//   mem_en/we/addr/wdata     memory command, mem_rdata one cycle after a read
//   owner                    1 only while requester 1 holds the grant
//   busy                     high in any granted state
module result_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req0_last,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic                  req1_last,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  // Beat index at which the grant must close because of MAX_HOLD.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [7:0] beat_cnt, beat_cnt_nxt;
  logic       grant_sel;
  logic       accept;
  logic       acc_last;
  logic       tie_pick1;
  logic       rd_pend_p1;
  logic       rd_tag_p1;

  // Stage p0: grant decode and memory command, all combinational from state.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      GRANT0:  req0_ready = req0_valid;
      GRANT1:  req1_ready = req1_valid;
      default: ;
    endcase
  end

  assign grant_sel = (state == GRANT1);
  assign accept    = req0_ready | req1_ready;
  assign acc_last  = grant_sel ? req1_last : req0_last;

  assign mem_en    = accept;
  assign mem_we    = accept & (grant_sel ? req1_we : req0_we);
  assign mem_addr  = grant_sel ? req1_addr  : req0_addr;
  assign mem_wdata = grant_sel ? req1_wdata : req0_wdata;

  assign owner = grant_sel;
  assign busy  = (state != IDLE);

`ifdef RESULT_ARB_FIXED_PRIO_EN
  assign tie_pick1 = 1'b0;
`else
  logic last_served;

  // A tie goes to whichever requester was not served most recently.
  assign tie_pick1 = ~last_served;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_served <= 1'b1;
    else if (state == IDLE && state_nxt != IDLE)
      last_served <= (state_nxt == GRANT1);
  end
`endif

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (req0_valid && req1_valid)
          state_nxt = tie_pick1 ? GRANT1 : GRANT0;
        else if (req0_valid)
          state_nxt = GRANT0;
        else if (req1_valid)
          state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        // In a grant state, accept is exactly the grantee's valid.
        if (!accept) begin
          state_nxt = IDLE;
        end else if (acc_last || beat_cnt == HOLD_LAST) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else begin
          beat_cnt_nxt = beat_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      rd_pend_p1 <= 1'b0;
      rd_tag_p1  <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      rd_pend_p1 <= accept & ~mem_we;
      if (accept && !mem_we)
        rd_tag_p1 <= grant_sel;
    end
  end

  // Stage p1: read return, aligned with the memory's registered read data.
  assign req0_rvalid = rd_pend_p1 & ~rd_tag_p1;
  assign req1_rvalid = rd_pend_p1 &  rd_tag_p1;
  assign req0_rdata  = mem_rdata;
  assign req1_rdata  = mem_rdata;

endmodule

// File: tb/tb_result_port_arbiter.sv
module tb_result_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_we, req0_last;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_we, req1_last;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          owner, busy;

  result_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_last(req1_last),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          last;
  } beat_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } memx_t;

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    int            cyc;
  } rdx_t;

  beat_t q0[$];
  beat_t q1[$];
  memx_t mem_q[$];
  rdx_t  rd_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int a);
    return 16'(32'hA5A5 ^ (a * 263));
  endfunction

  // Memory attached to the DUT: one-cycle registered read.
  logic [DW-1:0] ram   [0:(1<<AW)-1] = '{default: '0};
  logic          ram_w [0:(1<<AW)-1] = '{default: 1'b0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        ram_w[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
      end
    end
  end

  // Reference model: grant holder (-1 = nobody), beats served in this grant,
  // who was served last, and the expected memory contents.
  int            gr = -1;
  int            served = 0;
  int            last_srv = 1;
  logic          hold_valid = 1'b1;
  logic          m_acc = 1'b0;
  logic          m_last = 1'b0;
  logic          s_v0 = 1'b0;
  logic          s_v1 = 1'b0;
  logic [DW-1:0] shadow [int];

  function automatic logic [DW-1:0] rd_shadow(logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(int'(a));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(string nm, string info);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s at t=%0t", nm, info, $time);
  endtask

  task automatic push_burst(int who, int len, logic we, int base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.we    = we;
      b.addr  = AW'(base + k);
      b.wdata = DW'($urandom);
      b.last  = (k == len - 1);
      if (who == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic drive();
    req0_valid = (q0.size() != 0) && (hold_valid || $urandom_range(0, 7) != 0);
    req1_valid = (q1.size() != 0) && (hold_valid || $urandom_range(0, 7) != 0);
    if (q0.size() != 0) begin
      req0_we = q0[0].we; req0_addr = q0[0].addr;
      req0_wdata = q0[0].wdata; req0_last = q0[0].last;
    end else begin
      req0_we = 1'($urandom); req0_addr = AW'($urandom);
      req0_wdata = DW'($urandom); req0_last = 1'($urandom);
    end
    if (q1.size() != 0) begin
      req1_we = q1[0].we; req1_addr = q1[0].addr;
      req1_wdata = q1[0].wdata; req1_last = q1[0].last;
    end else begin
      req1_we = 1'($urandom); req1_addr = AW'($urandom);
      req1_wdata = DW'($urandom); req1_last = 1'($urandom);
    end
  endtask

  // Clock edge in the model: decide the next holder of the grant.
  task automatic advance();
    if (gr < 0) begin
      served = 0;
      if (s_v0 && s_v1) begin
`ifdef RESULT_ARB_FIXED_PRIO_EN
        gr = 0;
`else
        gr = (last_srv == 1) ? 0 : 1;
`endif
      end else if (s_v0) gr = 0;
      else if (s_v1) gr = 1;
      if (gr >= 0) last_srv = gr;
    end else if (!m_acc) begin
      gr = -1;
    end else begin
      if (gr == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      served++;
      if (m_last || served == MH) gr = -1;
    end
  endtask

  // Mid-cycle: compare handshake outputs and issue expectations.
  task automatic eval_check();
    beat_t b;
    s_v0 = req0_valid;
    s_v1 = req1_valid;
    chk("ready0", 32'(req0_ready), 32'(gr == 0 && s_v0));
    chk("ready1", 32'(req1_ready), 32'(gr == 1 && s_v1));
    chk("owner",  32'(owner), 32'(gr == 1));
    chk("busy",   32'(busy),  32'(gr >= 0));
    m_acc  = (gr == 0 && s_v0) || (gr == 1 && s_v1);
    m_last = 1'b0;
    if (m_acc) begin
      b = (gr == 0) ? q0[0] : q1[0];
      m_last = b.last;
      mem_q.push_back(memx_t'{b.we, b.addr, b.wdata});
      if (b.we) shadow[int'(b.addr)] = b.wdata;
      else rd_q.push_back(rdx_t'{gr, rd_shadow(b.addr), cyc + 1});
    end
  endtask

  task automatic step();
    @(posedge clk);
    advance();
    #1;
    drive();
    @(negedge clk);
    eval_check();
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || gr >= 0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) fail("drain_timeout", "traffic did not complete");
    step();
    step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready0"}, 32'(req0_ready), 0);
    chk({tag, "_ready1"}, 32'(req1_ready), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_owner"},  32'(owner), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_rvalid0"}, 32'(req0_rvalid), 0);
    chk({tag, "_rvalid1"}, 32'(req1_rvalid), 0);
  endtask

  task automatic reset_mid_burst();
    int k = 0;
    hold_valid = 1'b1;
    push_burst(1, 4, 1'b0, 10);
    while (!(gr == 1 && served == 1) && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) fail("rst_setup_timeout", "second beat never reached");
    rst = 1'b0;
    mem_q.delete();
    rd_q.delete();
    #1;
    chk_all_zero("rst_mid");
    q0.delete(); q1.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    gr = -1; served = 0; last_srv = 1;
    m_acc = 1'b0; m_last = 1'b0; s_v0 = 1'b0; s_v1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release_busy", 32'(busy), 0);
    chk("rst_release_owner", 32'(owner), 0);
  endtask

  // Monitor: memory commands and read returns against the queued expectations.
  initial begin
    memx_t me;
    rdx_t  re;
    forever begin
      @(negedge clk);
      #1;
      if (mem_en) begin
        if (mem_q.size() == 0) begin
          fail("mem_unexpected", $sformatf("addr %0h we %0b", mem_addr, mem_we));
        end else begin
          me = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(me.we));
          chk("mem_addr", 32'(mem_addr), 32'(me.addr));
          if (me.we) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
        end
      end else begin
        chk("mem_we_idle", 32'(mem_we), 0);
        if (mem_q.size() != 0) begin
          fail("mem_missing", $sformatf("addr %0h expected, mem_en low", mem_q[0].addr));
          mem_q.delete();
        end
      end
      if (req0_rvalid || req1_rvalid) begin
        if (rd_q.size() == 0) begin
          fail("rvalid_unexpected", $sformatf("rvalid0 %0b rvalid1 %0b", req0_rvalid, req1_rvalid));
        end else begin
          re = rd_q.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(re.cyc));
          chk("rvalid0", 32'(req0_rvalid), 32'(re.tag == 0));
          chk("rvalid1", 32'(req1_rvalid), 32'(re.tag == 1));
          chk("rdata", 32'(re.tag == 1 ? req1_rdata : req0_rdata), 32'(re.data));
        end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        fail("rvalid_missing", $sformatf("tag %0d data %0h", rd_q[0].tag, rd_q[0].data));
        void'(rd_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    hold_valid = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Both requesters valid straight out of reset, 2-beat bursts, then a second tie.
    push_burst(0, 2, 1'b1, 20);
    push_burst(1, 2, 1'b1, 24);
    drain(100);
    push_burst(0, 2, 1'b0, 20);
    push_burst(1, 2, 1'b0, 24);
    drain(100);

    // Three-beat write burst from requester 0 at addresses 5..7.
    push_burst(0, 3, 1'b1, 5);
    drain(100);

    // Twenty-beat read burst from requester 1, split by MAX_HOLD.
    push_burst(1, 20, 1'b0, 5);
    drain(200);

    // Requester 0 single read, requester 1 granted right after.
    push_burst(0, 1, 1'b0, 6);
    step();
    push_burst(1, 2, 1'b0, 7);
    drain(100);

    // Randomized traffic with valid gaps.
    hold_valid = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(0, $urandom_range(1, 20), 1'($urandom), $urandom_range(0, 31));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(1, $urandom_range(1, 20), 1'($urandom), $urandom_range(0, 31));
      step();
    end
    drain(2000);

    // Reset during the second beat of a 4-beat read from requester 1.
    reset_mid_burst();
    hold_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(0, $urandom_range(1, 12), 1'($urandom), $urandom_range(0, 31));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(1, $urandom_range(1, 12), 1'($urandom), $urandom_range(0, 31));
      step();
    end
    drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
